// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared definitions for the configuration-chain bitstream loader.
// Contents:
//   ccff_state_e           - loader FSM states (IDLE/FETCH/SHIFT/DONE)
//   CCFF_WORD_W_DEFAULT    - default bitstream word width
//   CCFF_CHAIN_LEN_DEFAULT - default configuration chain length
//   bit_cnt_width()        - width of the per-word bit counter
//   rem_cnt_width()        - width of the chain-bits-remaining counter
//   parity_accum()         - running XOR parity update
package ccff_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ccff_state_e;

    localparam int CCFF_WORD_W_DEFAULT    = 8;
    localparam int CCFF_CHAIN_LEN_DEFAULT = 64;

    // Counter must be able to hold WORD_W itself, hence the +1.
    function automatic int bit_cnt_width(input int word_w);
        return $clog2(word_w + 1);
    endfunction

    // Counter must be able to hold CHAIN_LEN itself, hence the +1.
    function automatic int rem_cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    function automatic logic parity_accum(input logic acc, input logic sample);
        return acc ^ sample;
    endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream word stream (valid/ready) between a word source and the loader.
// Signals:
//   word_data  - bitstream word, MSB shifted first
//   word_valid - source has a word on word_data
//   word_ready - loader takes word_data this cycle
// Modports: master = word source, slave = loader.
interface ccff_word_if
    import ccff_cfg_pkg::*;
#(
    parameter int WORD_W = CCFF_WORD_W_DEFAULT
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_bitstream_loader_shreg.sv
// Parallel-load, MSB-first shift register with a bits-remaining counter.
// Ports:
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   load_i        - capture load_data_i / load_cnt_i (wins over shift_i)
//   shift_i       - shift left by one, LSB filled with 0, counter - 1
//   load_data_i   - word to capture
//   load_cnt_i    - number of bits of this word that will be shifted out
//   msb_o         - current MSB (next bit out)
//   bit_cnt_o     - bits remaining in the current word
module ccff_piso_shreg #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] load_data_i,
    input  logic [CNT_W-1:0]  load_cnt_i,
    output logic              msb_o,
    output logic [CNT_W-1:0]  bit_cnt_o
);
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    // Next-state: a load on the last bit of a word replaces the shift, giving back-to-back words.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load_i) begin
            shreg_d   = load_data_i;
            bit_cnt_d = load_cnt_i;
        end else if (shift_i) begin
            shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end else begin
            shreg_d   = shreg_q;
            bit_cnt_d = bit_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign msb_o     = shreg_q[WORD_W-1];
    assign bit_cnt_o = bit_cnt_q;
endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain driver: serializes bitstream words onto ccff_head,
// issuing exactly CHAIN_LEN shift enables per load, and reports the parity
// of the previous chain contents seen on ccff_tail.
// Ports:
//   prog_clk, pReset - configuration clock, asynchronous active-high reset
//   start, abort     - load request (IDLE only) / cancel (FETCH/SHIFT)
//   word_if          - word stream, slave side
//   ccff_head        - serial data to the chain head
//   ccff_tail        - serial data from the chain tail
//   chain_shift_en   - chain shifts on this edge
//   busy, done       - load in progress / one-cycle completion pulse
//   aborted          - sticky, cleared by the next accepted start
//   tail_parity      - XOR of ccff_tail samples of the last load
module ccff_bitstream_loader
    import ccff_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = CCFF_CHAIN_LEN_DEFAULT,
    parameter int WORD_W    = CCFF_WORD_W_DEFAULT
) (
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       start,
    input  logic       abort,
    ccff_word_if.slave word_if,
    output logic       ccff_head,
    input  logic       ccff_tail,
    output logic       chain_shift_en,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       tail_parity
);
    localparam int BCW = bit_cnt_width(WORD_W);
    localparam int RCW = rem_cnt_width(CHAIN_LEN);

    ccff_state_e    state_q;
    logic [RCW-1:0] rem_cnt_q;
    logic           tail_parity_q;
    logic           aborted_q;

    logic [BCW-1:0] bit_cnt_s;
    logic [BCW-1:0] load_cnt_s;
    logic [RCW-1:0] rem_after_s;
    logic           shreg_msb_s;
    logic           in_fetch_s;
    logic           in_shift_s;
    logic           word_last_s;
    logic           chain_last_s;
    logic           shift_s;
    logic           ready_s;
    logic           accept_s;

    // Handshake and shift decode; abort suppresses both shift and ready in its own cycle.
    always_comb begin
        in_fetch_s   = (state_q == ST_FETCH);
        in_shift_s   = (state_q == ST_SHIFT);
        word_last_s  = (bit_cnt_s == BCW'(1));
        chain_last_s = (rem_cnt_q == RCW'(1));
        shift_s      = in_shift_s & ~abort;
        ready_s      = ~abort & (in_fetch_s | (in_shift_s & word_last_s & ~chain_last_s));
        accept_s     = ready_s & word_if.word_valid;
        // A word loaded during SHIFT starts after the current bit, so one fewer chain bit is left.
        if (in_shift_s) begin
            rem_after_s = rem_cnt_q - RCW'(1);
        end else begin
            rem_after_s = rem_cnt_q;
        end
        // The last word may be partial: only its top rem bits go out.
        if (int'(rem_after_s) >= WORD_W) begin
            load_cnt_s = BCW'(WORD_W);
        end else begin
            load_cnt_s = BCW'(rem_after_s);
        end
    end

    ccff_piso_shreg #(
        .WORD_W (WORD_W),
        .CNT_W  (BCW)
    ) u_piso (
        .clk_i       (prog_clk),
        .rst_i       (pReset),
        .load_i      (accept_s),
        .shift_i     (shift_s),
        .load_data_i (word_if.word_data),
        .load_cnt_i  (load_cnt_s),
        .msb_o       (shreg_msb_s),
        .bit_cnt_o   (bit_cnt_s)
    );

    // Loader FSM with chain-bit counter, tail parity and sticky abort flag.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q       <= ST_IDLE;
            rem_cnt_q     <= '0;
            tail_parity_q <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // start beats a simultaneous abort here.
                    if (start) begin
                        state_q       <= ST_FETCH;
                        rem_cnt_q     <= RCW'(CHAIN_LEN);
                        tail_parity_q <= 1'b0;
                        aborted_q     <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        aborted_q <= 1'b1;
                    end else if (accept_s) begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        aborted_q <= 1'b1;
                    end else begin
                        rem_cnt_q     <= rem_cnt_q - RCW'(1);
                        tail_parity_q <= parity_accum(tail_parity_q, ccff_tail);
                        if (chain_last_s) begin
                            state_q <= ST_DONE;
                        end else if (word_last_s && !accept_s) begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign word_if.word_ready = ready_s;
    assign ccff_head          = in_shift_s & shreg_msb_s;
    assign chain_shift_en     = shift_s;
    assign busy               = (state_q != ST_IDLE);
    assign done               = (state_q == ST_DONE);
    assign aborted            = aborted_q;
    assign tail_parity        = tail_parity_q;
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
module tb_ccff_bitstream_loader;
    logic       prog_clk = 1'b0;
    logic       pReset;
    logic       start, abort, ccff_tail, valid;
    logic [7:0] data;
    bit         sel;

    logic [7:0] words [0:7];
    int         gaps  [0:7];
    logic       tail_pat [0:31];

    int n_err    = 0;
    int n_checks = 0;

    logic head_a, en_a, busy_a, done_a, abt_a, par_a;
    logic head_b, en_b, busy_b, done_b, abt_b, par_b;
    logic obs_head, obs_en, obs_ready, obs_busy, obs_done, obs_abt, obs_par;

    ccff_word_if #(.WORD_W(8)) if_a ();
    ccff_word_if #(.WORD_W(8)) if_b ();

    assign if_a.word_data  = data;
    assign if_b.word_data  = data;
    assign if_a.word_valid = valid & ~sel;
    assign if_b.word_valid = valid & sel;

    ccff_bitstream_loader #(.CHAIN_LEN(10), .WORD_W(8)) dut_a (
        .prog_clk(prog_clk), .pReset(pReset), .start(start & ~sel), .abort(abort),
        .word_if(if_a), .ccff_head(head_a), .ccff_tail(ccff_tail),
        .chain_shift_en(en_a), .busy(busy_a), .done(done_a),
        .aborted(abt_a), .tail_parity(par_a));

    ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(start & sel), .abort(abort),
        .word_if(if_b), .ccff_head(head_b), .ccff_tail(ccff_tail),
        .chain_shift_en(en_b), .busy(busy_b), .done(done_b),
        .aborted(abt_b), .tail_parity(par_b));

    assign obs_head  = sel ? head_b : head_a;
    assign obs_en    = sel ? en_b : en_a;
    assign obs_ready = sel ? if_b.word_ready : if_a.word_ready;
    assign obs_busy  = sel ? busy_b : busy_a;
    assign obs_done  = sel ? done_b : done_a;
    assign obs_abt   = sel ? abt_b : abt_a;
    assign obs_par   = sel ? par_b : par_a;

    always #5 prog_clk = ~prog_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One load driven cycle by cycle; expectations come from words/gaps/tail_pat.
    task automatic run_load(input bit use_b, input int abort_after,
                            input bit extra_start, input bit abort_with_start);
        int cl, nwords, cyc, n_en, runs, exp_runs, done_cyc, done_cnt;
        int gap_left, nacc, exp_done, exp_en, abort_cyc;
        bit prev_en, ready_late, finished, busy_after;
        logic par_exp;
        logic [7:0] w;
        logic [31:0] head_obs, head_exp;
        cl = use_b ? 16 : 10;
        nwords = (cl + 7) / 8;
        sel = use_b;
        head_obs = 32'd0; head_exp = 32'd0; par_exp = 1'b0;
        n_en = 0; runs = 0; done_cyc = -1; done_cnt = 0; nacc = 0; abort_cyc = -1;
        prev_en = 1'b0; ready_late = 1'b0; finished = 1'b0; busy_after = 1'b1;
        gap_left = gaps[0];
        exp_en = (abort_after >= 0) ? abort_after : cl;
        exp_done = cl + 2;
        exp_runs = 1;
        for (int i = 0; i < nwords; i++) begin
            exp_done += gaps[i];
            if (i > 0 && gaps[i] > 0) exp_runs++;
        end
        for (int i = 0; i < exp_en; i++) begin
            w = words[i / 8];
            head_exp = {head_exp[30:0], w[7 - (i % 8)]};
            par_exp  = par_exp ^ tail_pat[i];
        end
        cyc = 0;
        while (!finished && cyc < 200) begin
            @(posedge prog_clk); #1;
            start = (cyc == 0) || (extra_start && cyc == 5);
            abort = (abort_with_start && cyc == 0) ||
                    (abort_after >= 0 && n_en == abort_after && cyc > 0);
            if (abort_after >= 0 && abort && abort_cyc < 0) abort_cyc = cyc;
            ccff_tail = tail_pat[n_en];
            @(negedge prog_clk);
            if (nacc == nwords && obs_ready) ready_late = 1'b1;
            if (nacc < nwords && obs_ready) begin
                if (gap_left > 0) begin
                    valid = 1'b0;
                    gap_left--;
                end else begin
                    valid = 1'b1;
                    data  = words[nacc];
                    nacc++;
                    gap_left = (nacc < nwords) ? gaps[nacc] : 0;
                end
            end else begin
                valid = (nacc < nwords) && (gap_left == 0);
                data  = (nacc < nwords) ? words[nacc] : 8'h00;
            end
            if (obs_en) begin
                head_obs = {head_obs[30:0], obs_head};
                n_en++;
                if (!prev_en) runs++;
            end
            prev_en = obs_en;
            if (obs_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end else if (done_cnt > 0) begin
                finished = 1'b1;
            end
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) busy_after = obs_busy;
            if (abort_cyc >= 0 && cyc == abort_cyc + 3) finished = 1'b1;
            cyc++;
        end
        start = 1'b0; abort = 1'b0; valid = 1'b0;
        chk("load_terminated", 32'(finished), 32'd1);
        chk("enable_count", 32'(n_en), 32'(exp_en));
        chk("head_sequence", head_obs, head_exp);
        chk("tail_parity", 32'(obs_par), 32'(par_exp));
        chk("aborted_flag", 32'(obs_abt), 32'(abort_after >= 0));
        chk("busy_at_end", 32'(obs_busy), 32'd0);
        if (abort_after < 0) begin
            chk("done_cycle", 32'(done_cyc), 32'(exp_done));
            chk("done_pulse_len", 32'(done_cnt), 32'd1);
            chk("enable_runs", 32'(runs), 32'(exp_runs));
            chk("ready_after_last", 32'(ready_late), 32'd0);
        end else begin
            chk("no_done_on_abort", 32'(done_cnt), 32'd0);
            chk("busy_after_abort", 32'(busy_after), 32'd0);
        end
    endtask

    initial begin
        int ab;
        bit ub;
        pReset = 1'b1; start = 1'b0; abort = 1'b0; ccff_tail = 1'b0;
        valid = 1'b0; data = 8'h00; sel = 1'b0;
        for (int i = 0; i < 8; i++) begin words[i] = 8'h00; gaps[i] = 0; end
        for (int i = 0; i < 32; i++) tail_pat[i] = 1'b0;
        #3;
        chk("reset_a", {25'd0, head_a, en_a, if_a.word_ready, busy_a, done_a, abt_a, par_a}, 32'd0);
        chk("reset_b", {25'd0, head_b, en_b, if_b.word_ready, busy_b, done_b, abt_b, par_b}, 32'd0);
        @(negedge prog_clk);
        @(negedge prog_clk);
        pReset = 1'b0;

        // Partial last word with the directed tail pattern (parity 0).
        words[0] = 8'hA5; words[1] = 8'hC0;
        tail_pat[0] = 1'b1; tail_pat[1] = 1'b1; tail_pat[3] = 1'b1; tail_pat[9] = 1'b1;
        run_load(1'b0, -1, 1'b0, 1'b0);

        // Stall of 4 cycles between the two words.
        gaps[1] = 4;
        for (int i = 0; i < 32; i++) tail_pat[i] = 1'($urandom);
        run_load(1'b0, -1, 1'b0, 1'b0);

        // Abort after the third shift, then a clean load clears aborted.
        gaps[1] = 0;
        words[0] = 8'($urandom); words[1] = 8'($urandom);
        run_load(1'b0, 3, 1'b0, 1'b0);
        run_load(1'b0, -1, 1'b0, 1'b0);

        // start together with abort in IDLE, plus a stray start mid-load.
        words[0] = 8'($urandom); words[1] = 8'($urandom);
        gaps[0] = 2; gaps[1] = 1;
        run_load(1'b0, -1, 1'b1, 1'b1);

        // Exact multiple on the 16-bit chain, no bubble.
        words[0] = 8'hFF; words[1] = 8'h00; gaps[0] = 0; gaps[1] = 0;
        run_load(1'b1, -1, 1'b0, 1'b0);

        // Reset asserted between edges during SHIFT.
        sel = 1'b0;
        @(posedge prog_clk); #1;
        start = 1'b1; valid = 1'b1; data = 8'h5A;
        @(posedge prog_clk); #1;
        start = 1'b0;
        @(posedge prog_clk);
        @(posedge prog_clk); #2;
        chk("shift_before_reset", 32'(en_a), 32'd1);
        pReset = 1'b1;
        #1;
        chk("reset_mid_shift", {25'd0, head_a, en_a, if_a.word_ready, busy_a, done_a, abt_a, par_a}, 32'd0);
        @(negedge prog_clk);
        pReset = 1'b0; valid = 1'b0;

        // Randomized loads on either chain, some aborted.
        for (int k = 0; k < 8; k++) begin
            ub = 1'($urandom);
            for (int i = 0; i < 4; i++) begin
                words[i] = 8'($urandom);
                gaps[i]  = int'($urandom_range(0, 3));
            end
            for (int i = 0; i < 32; i++) tail_pat[i] = 1'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, ub ? 15 : 9)) : -1;
            run_load(ub, ab, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
